// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 8-bit CPU instruction store
//
// Purpose: common definitions used by the program loader and its instruction RAM.
//   - loader_state_e : program loader FSM states
//   - PC_W           : CPU program counter width (fetch address width)
//   - INSTR_W        : instruction / stream byte width
//   - IMEM_DEPTH     : number of instruction words
//   - NOP_INSTR      : instruction returned for gated fetches (ADD R0,R0)
package cpu_pkg;

   localparam int PC_W       = 4;
   localparam int INSTR_W    = 8;
   localparam int IMEM_DEPTH = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR,
      LD_DATA,
      LD_CHK,
      LD_DONE,
      LD_ERR
   } loader_state_e;

endpackage

// File: rtl/cpu_instr_ram.sv
// rtl/cpu_instr_ram.sv - DEPTH x DATA_W instruction RAM, sync write, async read
//
// Purpose: storage array behind the CPU instruction store. Contents are not
// reset. A read of the address being written in the same cycle returns the
// old word.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational)
module cpu_instr_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - byte-stream program loader filling the CPU instruction RAM
//
// Purpose: accepts a stream "N, N instruction bytes [, checksum]" over a
// valid/ready handshake, writes the instructions into the instruction RAM and
// holds the CPU in reset until a complete, validated program is present.
// Optional feature macro: CPU_LOADER_CHECKSUM_EN (adds the trailing checksum
// byte; sum of instructions plus checksum must be 0 mod 256).
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   start         in   pulse; begins a load from IDLE/DONE/ERR
//   in_valid      in   in_data holds a valid stream byte
//   in_data       in   stream byte
//   in_ready      out  loader accepts a byte this cycle (registered)
//   fetch_addr    in   CPU PC
//   fetch_data    out  instruction at fetch_addr, NOP unless loaded and in range
//   cpu_hold      out  CPU must be held in reset
//   load_done     out  program loaded and valid
//   load_error    out  load aborted
//   words_loaded  out  instruction bytes written in the current load
module cpu_program_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = PC_W,
   parameter int DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [DATA_W-1:0] MAX_HDR = DATA_W'(DEPTH);

   loader_state_e     state_q;
   logic              in_ready_q;
   logic              cpu_hold_q;
   logic              load_done_q;
   logic              load_error_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  words_q;
   logic [ADDR_W-1:0] addr_q;

   logic              xfer;
   logic              hdr_ok;
   logic              last_byte;
   logic              ram_we;
   logic              fetch_hit;
   logic [DATA_W-1:0] ram_rdata;

`ifdef CPU_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
   logic [DATA_W-1:0] sum_d;

   // In DATA this is the running sum; in CHK it is sum + checksum byte.
   assign sum_d = sum_q + in_data;
`endif

   assign xfer      = in_valid && in_ready_q;
   assign hdr_ok    = (in_data != '0) && (in_data <= MAX_HDR);
   // words_q counts bytes already written, so this byte is the Nth one.
   assign last_byte = (words_q + LEN_W'(1)) == len_q;
   assign ram_we    = xfer && (state_q == LD_DATA);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LD_IDLE;
         in_ready_q   <= 1'b0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         len_q        <= '0;
         words_q      <= '0;
         addr_q       <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         case (state_q)
            LD_IDLE: begin
               if (start) begin
                  state_q    <= LD_HDR;
                  in_ready_q <= 1'b1;
               end
            end

            LD_HDR: begin
               if (xfer) begin
                  if (hdr_ok) begin
                     state_q <= LD_DATA;
                     len_q   <= in_data[ADDR_W:0];
                     addr_q  <= '0;
                     words_q <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
                     sum_q   <= '0;
`endif
                  end else begin
                     state_q      <= LD_ERR;
                     in_ready_q   <= 1'b0;
                     load_error_q <= 1'b1;
                  end
               end
            end

            LD_DATA: begin
               if (xfer) begin
                  // addr wraps to 0 after a full-depth load; DATA exits on that edge.
                  addr_q  <= addr_q + ADDR_W'(1);
                  words_q <= words_q + LEN_W'(1);
`ifdef CPU_LOADER_CHECKSUM_EN
                  sum_q   <= sum_d;
`endif
                  if (last_byte) begin
`ifdef CPU_LOADER_CHECKSUM_EN
                     state_q     <= LD_CHK;
`else
                     state_q     <= LD_DONE;
                     in_ready_q  <= 1'b0;
                     cpu_hold_q  <= 1'b0;
                     load_done_q <= 1'b1;
`endif
                  end
               end
            end

`ifdef CPU_LOADER_CHECKSUM_EN
            LD_CHK: begin
               if (xfer) begin
                  in_ready_q <= 1'b0;
                  if (sum_d == '0) begin
                     state_q     <= LD_DONE;
                     cpu_hold_q  <= 1'b0;
                     load_done_q <= 1'b1;
                  end else begin
                     state_q      <= LD_ERR;
                     load_error_q <= 1'b1;
                  end
               end
            end
`endif

            LD_DONE, LD_ERR: begin
               if (start) begin
                  state_q      <= LD_HDR;
                  in_ready_q   <= 1'b1;
                  cpu_hold_q   <= 1'b1;
                  load_done_q  <= 1'b0;
                  load_error_q <= 1'b0;
               end
            end

            default: begin
               state_q      <= LD_IDLE;
               in_ready_q   <= 1'b0;
               cpu_hold_q   <= 1'b1;
               load_done_q  <= 1'b0;
               load_error_q <= 1'b0;
            end
         endcase
      end
   end

   cpu_instr_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (addr_q),
      .wdata_i (in_data),
      .raddr_i (fetch_addr),
      .rdata_o (ram_rdata)
   );

   // Partial or stale RAM contents stay invisible: only a completed load
   // exposes words, and only those below len.
   assign fetch_hit  = (state_q == LD_DONE) && ({1'b0, fetch_addr} < len_q);
   assign fetch_data = fetch_hit ? ram_rdata : DATA_W'(NOP_INSTR);

   assign in_ready     = in_ready_q;
   assign cpu_hold     = cpu_hold_q;
   assign load_done    = load_done_q;
   assign load_error   = load_error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - self-checking bench for cpu_program_loader
module tb_cpu_program_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] fetch_addr;
   logic [7:0] fetch_data;
   logic       cpu_hold;
   logic       load_done;
   logic       load_error;
   logic [4:0] words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_mem [16];
   int         m_words;

   typedef struct packed {
      int              nbytes;
      logic [5:0][7:0] b;
      logic            exp_done;
      logic            exp_err;
      logic [4:0]      exp_words;
      logic [3:0][7:0] exp_f;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   cpu_program_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .fetch_addr   (fetch_addr),
      .fetch_data   (fetch_data),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit accepted;
      int budget;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      accepted = 1'b0;
      budget   = 0;
      while (!accepted && budget < 20) begin
         accepted = in_ready;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: byte %0h not accepted within 20 cycles", b);
      end
   endtask

   function automatic logic [7:0] chk_of(input int n);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < n; i++) s = s + m_mem[i];
      return 8'h00 - s;
   endfunction

   // Send header, the first n bytes of m_mem and (when enabled) the checksum byte.
   task automatic send_program(input int n, input bit gaps, input bit corrupt);
      send_byte(8'(n), gaps);
      for (int i = 0; i < n; i++) send_byte(m_mem[i], gaps);
`ifdef CPU_LOADER_CHECKSUM_EN
      send_byte(chk_of(n) ^ {7'b0, corrupt}, gaps);
`else
      if (corrupt) check("corrupt_unused", 32'(corrupt), 32'(0));
`endif
   endtask

   task automatic check_fetch_all(input string tag, input bit done_exp, input int len);
      logic [7:0] exp;
      for (int a = 0; a < 16; a++) begin
         fetch_addr = 4'(a);
         #1;
         exp = (done_exp && a < len) ? m_mem[a] : 8'h00;
         check($sformatf("%s_fetch%0d", tag, a), 32'(fetch_data), 32'(exp));
      end
   endtask

   task automatic check_status(input string tag, input bit done_exp, input int words_exp);
      check({tag, "_done"},  32'(load_done),    32'(done_exp));
      check({tag, "_err"},   32'(load_error),   32'(!done_exp));
      check({tag, "_hold"},  32'(cpu_hold),     32'(!done_exp));
      check({tag, "_ready"}, 32'(in_ready),     32'(0));
      check({tag, "_words"}, 32'(words_loaded), 32'(words_exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      fetch_addr = 4'h0;

      // Stream-level vectors; expectations are hand-derived constants.
      vecs[1] = '{nbytes: 1, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  exp_done: 1'b0, exp_err: 1'b1, exp_words: 5'd3,
                  exp_f: {8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[2] = '{nbytes: 1, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11},
                  exp_done: 1'b0, exp_err: 1'b1, exp_words: 5'd3,
                  exp_f: {8'h00, 8'h00, 8'h00, 8'h00}};
`ifdef CPU_LOADER_CHECKSUM_EN
      vecs[0] = '{nbytes: 5, b: {8'h00, 8'hEA, 8'hC3, 8'hB2, 8'hA1, 8'h03},
                  exp_done: 1'b1, exp_err: 1'b0, exp_words: 5'd3,
                  exp_f: {8'h00, 8'hC3, 8'hB2, 8'hA1}};
      vecs[3] = '{nbytes: 5, b: {8'h00, 8'hEB, 8'hC3, 8'hB2, 8'hA1, 8'h03},
                  exp_done: 1'b0, exp_err: 1'b1, exp_words: 5'd3,
                  exp_f: {8'h00, 8'h00, 8'h00, 8'h00}};
`else
      vecs[0] = '{nbytes: 4, b: {8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h03},
                  exp_done: 1'b1, exp_err: 1'b0, exp_words: 5'd3,
                  exp_f: {8'h00, 8'hC3, 8'hB2, 8'hA1}};
      vecs[3] = '{nbytes: 2, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h01},
                  exp_done: 1'b1, exp_err: 1'b0, exp_words: 5'd1,
                  exp_f: {8'h00, 8'h00, 8'h00, 8'h5A}};
`endif

      tick();
      tick();
      reset = 1'b0;
      check("rst_ready", 32'(in_ready), 32'(0));
      check("rst_hold",  32'(cpu_hold), 32'(1));
      check("rst_done",  32'(load_done), 32'(0));
      check("rst_err",   32'(load_error), 32'(0));
      check("rst_words", 32'(words_loaded), 32'(0));
      #1;
      check("rst_fetch0", 32'(fetch_data), 32'(0));

      for (int v = 0; v < 4; v++) begin
         pulse_start();
         for (int j = 0; j < vecs[v].nbytes; j++) send_byte(vecs[v].b[j], 1'b0);
         // Sampled the cycle right after the final accepting edge.
         check($sformatf("vec%0d_done", v),  32'(load_done),    32'(vecs[v].exp_done));
         check($sformatf("vec%0d_err", v),   32'(load_error),   32'(vecs[v].exp_err));
         check($sformatf("vec%0d_hold", v),  32'(cpu_hold),     32'(!vecs[v].exp_done));
         check($sformatf("vec%0d_ready", v), 32'(in_ready),     32'(0));
         check($sformatf("vec%0d_words", v), 32'(words_loaded), 32'(vecs[v].exp_words));
         for (int a = 0; a < 4; a++) begin
            fetch_addr = 4'(a);
            #1;
            check($sformatf("vec%0d_fetch%0d", v, a), 32'(fetch_data), 32'(vecs[v].exp_f[a]));
         end
         if (v == 0) begin
            // A trailing byte after DONE must not be consumed.
            in_valid = 1'b1;
            in_data  = 8'h77;
            tick();
            in_valid = 1'b0;
            check("extra_byte_done",  32'(load_done),    32'(1));
            check("extra_byte_words", 32'(words_loaded), 32'(3));
            fetch_addr = 4'h2;
            #1;
            check("extra_byte_fetch2", 32'(fetch_data), 32'(8'hC3));
         end
      end

      // Reset in the middle of a load.
      pulse_start();
      send_byte(8'h05, 1'b0);
      send_byte(8'h99, 1'b0);
      send_byte(8'h98, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_ready", 32'(in_ready), 32'(0));
      check("midrst_hold",  32'(cpu_hold), 32'(1));
      check("midrst_done",  32'(load_done), 32'(0));
      check("midrst_err",   32'(load_error), 32'(0));
      check("midrst_words", 32'(words_loaded), 32'(0));
      fetch_addr = 4'h0;
      #1;
      check("midrst_fetch0", 32'(fetch_data), 32'(0));
      m_mem[0] = 8'h11;
      m_mem[1] = 8'h22;
      pulse_start();
      send_program(2, 1'b0, 1'b0);
      check_status("after_rst", 1'b1, 2);
      check_fetch_all("after_rst", 1'b1, 2);

      // start while in DATA is ignored.
      m_mem[0] = 8'h44;
      m_mem[1] = 8'h55;
      m_mem[2] = 8'h66;
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_byte(m_mem[0], 1'b0);
      pulse_start();
      check("start_in_data_ready", 32'(in_ready), 32'(1));
      check("start_in_data_hold",  32'(cpu_hold), 32'(1));
      send_byte(m_mem[1], 1'b0);
      send_byte(m_mem[2], 1'b0);
`ifdef CPU_LOADER_CHECKSUM_EN
      send_byte(chk_of(3), 1'b0);
`endif
      check_status("start_in_data", 1'b1, 3);
      check_fetch_all("start_in_data", 1'b1, 3);

      // start while in DONE: back to HDR on the next edge.
      pulse_start();
      check("start_in_done_hold",  32'(cpu_hold),  32'(1));
      check("start_in_done_done",  32'(load_done), 32'(0));
      check("start_in_done_ready", 32'(in_ready),  32'(1));
      fetch_addr = 4'h0;
      #1;
      check("start_in_done_fetch0", 32'(fetch_data), 32'(0));

      // Full-depth load with random gaps on in_valid (already in HDR).
      for (int i = 0; i < 16; i++) m_mem[i] = 8'(i);
      send_program(16, 1'b1, 1'b0);
      check_status("full", 1'b1, 16);
      check_fetch_all("full", 1'b1, 16);
      m_words = 16;

      // Randomized loads against the stream-level reference model.
      for (int it = 0; it < 24; it++) begin
         int  n;
         bit  legal;
         bit  corrupt;
         bit  ok;
         n       = int'($urandom_range(0, 17));
         legal   = (n >= 1) && (n <= 16);
`ifdef CPU_LOADER_CHECKSUM_EN
         corrupt = ($urandom_range(0, 3) == 0);
`else
         corrupt = 1'b0;
`endif
         for (int i = 0; i < 16; i++) m_mem[i] = 8'($urandom);
         pulse_start();
         if (legal) begin
            send_program(n, 1'b1, corrupt);
            m_words = n;
         end else begin
            send_byte(8'(n), 1'b1);
         end
         ok = legal && !corrupt;
         check_status($sformatf("rnd%0d", it), ok, m_words);
         check_fetch_all($sformatf("rnd%0d", it), ok, n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
